// File: rtl/header_pkg.sv
// Shared types and constants for the byte-stream header sync path.
package header_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    EXP_B   = 2'd1,
    EXP_A   = 2'd2,
    PAYLOAD = 2'd3
  } hdr_state_e;

  localparam logic [7:0] HDR_A_DEF = 8'h55;
  localparam logic [7:0] HDR_B_DEF = 8'hD5;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/header_sync_ctrl.sv
// Preamble hunter / framer: locks after HDR_REPS {HDR_A,HDR_B} pairs, then
// gates PLD_LEN payload bytes out with sof/eof and returns to hunting.
module header_sync_ctrl
  import header_pkg::*;
#(
  parameter logic [7:0] HDR_A    = HDR_A_DEF,
  parameter logic [7:0] HDR_B    = HDR_B_DEF,
  parameter int         HDR_REPS = 5,
  parameter int         PLD_LEN  = 16,
  parameter int         ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       din,
  input  logic             din_vld,
  output logic [7:0]       dout,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic             hdr_det,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RW = cnt_w(HDR_REPS);
  localparam int PW = cnt_w(PLD_LEN);
  localparam logic [RW-1:0] REP_LAST = RW'(HDR_REPS - 1);
  localparam logic [PW-1:0] PLD_LAST = PW'(PLD_LEN - 1);

  hdr_state_e    state, state_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic [PW-1:0] pld_cnt, pld_nxt;
  logic          err_inc, hdr_nxt, ovld_nxt, sof_nxt, eof_nxt;

  // Next-state and next-output decode; only qualified bytes advance anything.
  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    pld_nxt   = pld_cnt;
    err_inc   = 1'b0;
    hdr_nxt   = 1'b0;
    ovld_nxt  = 1'b0;
    sof_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    if (!en) begin
      // Abort: truncated frames are dropped silently, not counted as errors.
      state_nxt = HUNT;
      rep_nxt   = '0;
      pld_nxt   = '0;
    end else if (din_vld) begin
      unique case (state)
        HUNT: begin
          if (din == HDR_A) state_nxt = EXP_B;
        end
        EXP_B: begin
          if (din == HDR_B) begin
            if (rep_cnt == REP_LAST) begin
              rep_nxt   = '0;
              hdr_nxt   = 1'b1;
              state_nxt = PAYLOAD;
            end else begin
              rep_nxt   = rep_cnt + RW'(1);
              state_nxt = EXP_A;
            end
          end else begin
            err_inc   = 1'b1;
            rep_nxt   = '0;
            // A stray HDR_A may be the start of a fresh preamble: resync on it.
            state_nxt = (din == HDR_A) ? EXP_B : HUNT;
          end
        end
        EXP_A: begin
          if (din == HDR_A) begin
            state_nxt = EXP_B;
          end else begin
            err_inc   = 1'b1;
            rep_nxt   = '0;
            state_nxt = HUNT;
          end
        end
        PAYLOAD: begin
          // Header bytes inside the payload are plain data.
          ovld_nxt = 1'b1;
          sof_nxt  = (pld_cnt == '0);
          if (pld_cnt == PLD_LAST) begin
            eof_nxt   = 1'b1;
            pld_nxt   = '0;
            state_nxt = HUNT;
          end else begin
            pld_nxt = pld_cnt + PW'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      rep_cnt  <= '0;
      pld_cnt  <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sof <= 1'b0;
      dout_eof <= 1'b0;
      hdr_det  <= 1'b0;
      locked   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rep_cnt  <= rep_nxt;
      pld_cnt  <= pld_nxt;
      if (ovld_nxt) dout <= din;
      dout_vld <= ovld_nxt;
      dout_sof <= sof_nxt;
      dout_eof <= eof_nxt;
      hdr_det  <= hdr_nxt;
      locked   <= (state_nxt == PAYLOAD);
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_header_sync_ctrl.sv
// Scoreboard bench for header_sync_ctrl: expected payload beats are queued as
// bytes are driven and popped when the DUT emits them.
module tb_header_sync_ctrl;
  import header_pkg::*;

  localparam int REPS = 5;
  localparam int PLEN = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic [7:0] dout;
  logic       dout_vld, dout_sof, dout_eof, hdr_det, locked;
  logic [7:0] err_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hdr_seen = 0;
  int   lock_cyc = 0;

  header_sync_ctrl #(
    .HDR_A(8'h55), .HDR_B(8'hD5), .HDR_REPS(REPS), .PLD_LEN(PLEN), .ERR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_vld(din_vld),
    .dout(dout), .dout_vld(dout_vld), .dout_sof(dout_sof), .dout_eof(dout_eof),
    .hdr_det(hdr_det), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every payload beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (hdr_det) hdr_seen++;
    if (locked)  lock_cyc++;
    if (dout_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {24'h0, dout}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", {24'h0, dout}, {24'h0, e.d});
        chk("sof",  {31'h0, dout_sof}, {31'h0, e.sof});
        chk("eof",  {31'h0, dout_eof}, {31'h0, e.eof});
      end
    end
  end

  // Inputs change on negedge, DUT samples on posedge, outputs checked next negedge.
  task automatic drv(input logic [7:0] b);
    din = b; din_vld = 1'b1;
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; din_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pre(input int n);
    repeat (n) begin drv(8'h55); drv(8'hD5); end
  endtask

  // Full preamble with a check that hdr_det/locked rise exactly after the last HDR_B.
  task automatic lock_seq(input string tag);
    pre(REPS - 1);
    drv(8'h55);
    chk({tag, "_hdr_early"}, {31'h0, hdr_det}, 32'h0);
    drv(8'hD5);
    chk({tag, "_hdr_det"}, {31'h0, hdr_det}, 32'h1);
    chk({tag, "_locked"},  {31'h0, locked},  32'h1);
  endtask

  // Payload including header-valued bytes; gap idle cycles between beats.
  task automatic pld(input int gap);
    for (int i = 0; i < PLEN; i++) begin
      exp_t e;
      e.d   = (i == 9) ? 8'hD5 : 8'h50 + 8'(i);
      e.sof = (i == 0);
      e.eof = (i == PLEN - 1);
      sb.push_back(e);
      drv(e.d);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    int h0, l0;
    do_reset();
    chk("rst_dout",  {24'h0, dout}, 32'h0);
    chk("rst_vld",   {31'h0, dout_vld}, 32'h0);
    chk("rst_flags", {29'h0, dout_sof, dout_eof, hdr_det}, 32'h0);
    chk("rst_locked",{31'h0, locked}, 32'h0);
    chk("rst_err",   {24'h0, err_cnt}, 32'h0);

    // 1: clean lock, payload 00..0F
    h0 = hdr_seen; l0 = lock_cyc;
    lock_seq("t1");
    for (int i = 0; i < PLEN; i++) begin
      exp_t e;
      e.d = 8'(i); e.sof = (i == 0); e.eof = (i == PLEN - 1);
      sb.push_back(e);
      drv(e.d);
    end
    chk("t1_unlocked", {31'h0, locked}, 32'h0);
    idle(3);
    chk("t1_hdr_count", hdr_seen - h0, 1);
    chk("t1_lock_cycles", lock_cyc - l0, PLEN);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_err", {24'h0, err_cnt}, 32'h0);

    // 2: broken preamble, then a clean one still locks
    do_reset();
    h0 = hdr_seen;
    pre(2); drv(8'h00);
    chk("t2_err", {24'h0, err_cnt}, 32'h1);
    chk("t2_no_hdr", hdr_seen - h0, 0);
    lock_seq("t2");
    pld(0); idle(2);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_err_hold", {24'h0, err_cnt}, 32'h1);

    // 3: near-miss bytes never leave HUNT
    do_reset();
    h0 = hdr_seen;
    repeat (3) begin drv(8'h56); drv(8'hD6); end
    idle(2);
    chk("t3_no_hdr", hdr_seen - h0, 0);
    chk("t3_err", {24'h0, err_cnt}, 32'h0);
    chk("t3_locked", {31'h0, locked}, 32'h0);

    // 4: HDR_A in EXP_B counts an error and resyncs
    do_reset();
    h0 = hdr_seen;
    drv(8'h55); drv(8'hD5); drv(8'h55);
    drv(8'h55);
    chk("t4_err", {24'h0, err_cnt}, 32'h1);
    drv(8'hD5);
    pre(3);
    chk("t4_no_hdr_yet", hdr_seen - h0, 0);
    drv(8'h55); drv(8'hD5);
    chk("t4_hdr_det", {31'h0, hdr_det}, 32'h1);
    pld(0); idle(2);
    chk("t4_hdr_count", hdr_seen - h0, 1);
    chk("t4_err_final", {24'h0, err_cnt}, 32'h1);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: payload with din_vld toggling
    do_reset();
    lock_seq("t5");
    pld(1); idle(3);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_locked", {31'h0, locked}, 32'h0);

    // 6: enable drop mid-frame, then relock, then error saturation
    do_reset();
    lock_seq("t6");
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.d = 8'hA0 + 8'(i); e.sof = (i == 0); e.eof = 1'b0;
      sb.push_back(e);
      drv(e.d);
    end
    en = 1'b0;
    drv(8'hA4);
    chk("t6_abort_vld", {31'h0, dout_vld}, 32'h0);
    chk("t6_abort_locked", {31'h0, locked}, 32'h0);
    chk("t6_abort_eof", {31'h0, dout_eof}, 32'h0);
    chk("t6_abort_err", {24'h0, err_cnt}, 32'h0);
    en = 1'b1;
    idle(2);
    chk("t6_sb_empty_abort", sb.size(), 0);
    lock_seq("t6r");
    pld(0); idle(2);
    chk("t6_sb_empty", sb.size(), 0);
    repeat (254) begin drv(8'h55); drv(8'h00); end
    chk("t6_err_254", {24'h0, err_cnt}, 32'hFE);
    repeat (10) begin drv(8'h55); drv(8'h00); end
    chk("t6_err_sat", {24'h0, err_cnt}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
